// File: rtl/bar_stream_reader_pkg.sv
// Shared types and default widths for the BAR-based memory stream reader.
package bar_stream_reader_pkg;

    localparam int RD_DW = 8;
    localparam int RD_AW = 8;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_PRESENT,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/bar_stream_reader.sv
// Streams len bytes from data memory, starting at the latched BAR base, out on a valid/ready port.
// state      | meaning
// RD_IDLE    | waiting for start; base/len latched on start
// RD_ISSUE   | read strobe for address base+idx
// RD_WAIT    | memory data arrives, captured into output register
// RD_PRESENT | byte held on out_data until out_ready
// RD_DONE    | one-cycle done pulse
module bar_stream_reader
    import bar_stream_reader_pkg::*;
#(
    parameter int DW = RD_DW,
    parameter int AW = RD_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] bar_base,
    input  logic [7:0]    len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    rd_state_t     r_state;
    rd_state_t     w_state_next;
    logic [AW-1:0] r_base;
    logic [7:0]    r_cnt;
    logic [7:0]    r_idx;
    logic [DW-1:0] r_out_data;
    logic [7:0]    w_idx_inc;
    logic          w_mem_re;
    logic          w_out_valid;
    logic          w_done;

    assign w_idx_inc = r_idx + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RD_IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                RD_IDLE: begin
                    if (start) begin
                        r_base <= bar_base;
                        r_cnt  <= len;
                        r_idx  <= '0;
                    end
                end
                RD_WAIT:    r_out_data <= mem_dout;
                RD_PRESENT: if (out_ready) r_idx <= w_idx_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_re     = 1'b0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (start) w_state_next = (len == 8'd0) ? RD_DONE : RD_ISSUE;
            end
            RD_ISSUE: begin
                w_mem_re     = 1'b1;
                w_state_next = RD_WAIT;
            end
            RD_WAIT: w_state_next = RD_PRESENT;
            RD_PRESENT: begin
                w_out_valid = 1'b1;
                if (out_ready) w_state_next = (w_idx_inc == r_cnt) ? RD_DONE : RD_ISSUE;
            end
            RD_DONE: begin
                w_done       = 1'b1;
                w_state_next = RD_IDLE;
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    // Address wraps naturally at 2^AW; only meaningful while mem_re is high.
    assign mem_addr  = r_base + AW'(r_idx);
    assign mem_re    = w_mem_re;
    assign out_data  = r_out_data;
    assign out_valid = w_out_valid;
    assign busy      = (r_state != RD_IDLE);
    assign done      = w_done;

endmodule

// File: tb/tb_bar_stream_reader.sv
// Directed bench for bar_stream_reader with a synchronous memory model and hand-computed expectations.
module tb_bar_stream_reader;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] bar_base;
    logic [7:0] len;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_dout;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [7:0] tb_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    int         q_vcyc[$];
    int         q_done[$];
    int         stall_cnt;
    int         hold_bad;

    bar_stream_reader #(.DW(8), .AW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bar_base  (bar_base),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_dout  (mem_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_dout <= tb_mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start for one edge; returns at the falling edge of cycle k+1.
    task automatic start_xfer(input logic [7:0] b, input logic [7:0] l);
        q_addr.delete();
        q_data.delete();
        q_vcyc.delete();
        q_done.delete();
        stall_cnt = 0;
        hold_bad  = 0;
        start     = 1'b1;
        bar_base  = b;
        len       = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples cycles k+1..k+n; optional stall window and a stray start at cycle restart_at.
    task automatic observe(input int n, input int stall_from, input int stall_len, input int restart_at);
        logic [7:0] held;
        held = 8'h00;
        for (int c = 1; c <= n; c++) begin
            out_ready = !(c >= stall_from && c < stall_from + stall_len);
            if (c == restart_at) begin
                start    = 1'b1;
                bar_base = 8'h80;
                len      = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (mem_re) q_addr.push_back(mem_addr);
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_vcyc.push_back(c);
            end
            if (out_valid && !out_ready) begin
                if (stall_cnt > 0 && out_data !== held) hold_bad++;
                held = out_data;
                stall_cnt++;
            end
            if (done) q_done.push_back(c);
            @(negedge clk);
        end
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        tb_mem[8'h10] = 8'hA1; tb_mem[8'h11] = 8'hB2; tb_mem[8'h12] = 8'hC3;
        tb_mem[8'hFE] = 8'h5A; tb_mem[8'hFF] = 8'h6B; tb_mem[8'h00] = 8'h7C; tb_mem[8'h01] = 8'h8D;
        tb_mem[8'h20] = 8'h11; tb_mem[8'h21] = 8'h22; tb_mem[8'h22] = 8'h33;
        tb_mem[8'h80] = 8'hEE;

        reset_n   = 1'b0;
        start     = 1'b0;
        bar_base  = 8'h00;
        len       = 8'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_data", out_data, 8'h00);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // base 0x10, len 3, out_ready high
        start_xfer(8'h10, 8'd3);
        chk("s1_issue_re", mem_re, 1);
        chk("s1_issue_addr", mem_addr, 8'h10);
        observe(10, 0, 0, 0);
        chk("s1_naddr", q_addr.size(), 3);
        chk("s1_addr0", q_addr[0], 8'h10);
        chk("s1_addr1", q_addr[1], 8'h11);
        chk("s1_addr2", q_addr[2], 8'h12);
        chk("s1_nbytes", q_data.size(), 3);
        chk("s1_byte0", q_data[0], 8'hA1);
        chk("s1_byte1", q_data[1], 8'hB2);
        chk("s1_byte2", q_data[2], 8'hC3);
        chk("s1_vcyc0", q_vcyc[0], 3);
        chk("s1_vcyc1", q_vcyc[1], 6);
        chk("s1_vcyc2", q_vcyc[2], 9);
        chk("s1_ndone", q_done.size(), 1);
        chk("s1_done_cyc", q_done[0], 10);
        chk("s1_idle_busy", busy, 0);

        // back-to-back start in first IDLE cycle; address wraps 0xFF->0x00
        start_xfer(8'hFE, 8'd4);
        observe(13, 0, 0, 0);
        chk("s2_naddr", q_addr.size(), 4);
        chk("s2_addr0", q_addr[0], 8'hFE);
        chk("s2_addr1", q_addr[1], 8'hFF);
        chk("s2_addr2", q_addr[2], 8'h00);
        chk("s2_addr3", q_addr[3], 8'h01);
        chk("s2_byte0", q_data[0], 8'h5A);
        chk("s2_byte1", q_data[1], 8'h6B);
        chk("s2_byte2", q_data[2], 8'h7C);
        chk("s2_byte3", q_data[3], 8'h8D);
        chk("s2_done_cyc", q_done[0], 13);
        chk("s2_idle_busy", busy, 0);

        // backpressure: byte 2 presented at cycle 6, held for 5 cycles
        start_xfer(8'h10, 8'd3);
        observe(15, 6, 5, 0);
        chk("s3_stall_cnt", stall_cnt, 5);
        chk("s3_hold_bad", hold_bad, 0);
        chk("s3_naddr", q_addr.size(), 3);
        chk("s3_nbytes", q_data.size(), 3);
        chk("s3_byte0", q_data[0], 8'hA1);
        chk("s3_byte1", q_data[1], 8'hB2);
        chk("s3_byte2", q_data[2], 8'hC3);
        chk("s3_vcyc1", q_vcyc[1], 11);
        chk("s3_done_cyc", q_done[0], 15);

        // zero-length transfer
        @(negedge clk);
        start_xfer(8'h10, 8'd0);
        observe(3, 0, 0, 0);
        chk("s4_naddr", q_addr.size(), 0);
        chk("s4_nbytes", q_data.size(), 0);
        chk("s4_ndone", q_done.size(), 1);
        chk("s4_done_cyc", q_done[0], 1);
        chk("s4_idle_busy", busy, 0);

        // stray start with new base while busy
        start_xfer(8'h20, 8'd3);
        observe(10, 0, 0, 4);
        chk("s5_naddr", q_addr.size(), 3);
        chk("s5_addr0", q_addr[0], 8'h20);
        chk("s5_addr1", q_addr[1], 8'h21);
        chk("s5_addr2", q_addr[2], 8'h22);
        chk("s5_byte0", q_data[0], 8'h11);
        chk("s5_byte1", q_data[1], 8'h22);
        chk("s5_byte2", q_data[2], 8'h33);
        chk("s5_ndone", q_done.size(), 1);
        chk("s5_done_cyc", q_done[0], 10);
        chk("s5_idle_busy", busy, 0);

        // asynchronous reset while a byte is presented
        start_xfer(8'h10, 8'd3);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_present_valid", out_valid, 1);
        chk("s6_present_data", out_data, 8'hA1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_mem_re", mem_re, 0);
        chk("s6_rst_data", out_data, 8'h00);
        chk("s6_rst_addr", mem_addr, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("s6_no_done", done, 0);
        end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("s6_after_done", done, 0);
            chk("s6_after_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bar_stream_reader.md
# bar_stream_reader

Sequential reader that consumes the base-address register value (the BAR byte) and streams a run of bytes out of synchronous data memory to the stack datapath. On `start` it latches the BAR byte and a length, reads `len` consecutive bytes beginning at that address, and presents each byte on a valid/ready output. It is the read-side counterpart of the BAR write path: the core writes the base, and this block walks memory from it.

## Interface

- `DW`, 8: data width of memory words and output bytes.
- `AW`, 8: address width; equals BAR width.

- `clk`  input  1  system clock; all state updates on posedge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a transfer; sampled only in IDLE.
- `bar_base`  input  AW  base address, driven from the BAR register output.
- `len`  input  8  number of bytes to read, 0..255.
- `mem_addr`  output  AW  data-memory read address.
- `mem_re`  output  1  data-memory read strobe.
- `mem_dout`  input  DW  memory read data, valid the cycle after `mem_re`.
- `out_data`  output  DW  streamed byte.
- `out_valid`  output  1  `out_data` holds a valid byte.
- `out_ready`  input  1  consumer accepts the byte this cycle.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse at the end of each transfer.

## Operation

- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: on `start=1`, latch `base<=bar_base`, `cnt<=len`, `idx<=0`. If `len==0`, go to DONE; otherwise go to ISSUE.
- ISSUE: `mem_re=1`, `mem_addr=base+idx` (mod 2^AW, wraps 0xFF->0x00). Go to WAIT.
- WAIT: `mem_re=0`. Capture `mem_dout` into the `out_data` register. Go to PRESENT.
- PRESENT: `out_valid=1`, `out_data` stable. On `out_ready=1`: `idx<=idx+1`, then go to DONE if `idx+1==cnt`, else go to ISSUE. Without `out_ready`, stay in PRESENT and hold the byte indefinitely.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `bar_base` and `len` changes after latch have no effect on the transfer in flight.
- `busy = (state != IDLE)`.
- `mem_addr` is driven `base+idx` in every state. It is only meaningful when `mem_re=1`.
- `idx` is 8 bits. `cnt` is at most 255, so `idx` never overflows before `idx+1==cnt`.

## Timing

- Reset (asynchronous, `reset_n=0`) forces: state=IDLE, `out_valid=0`, `out_data=0`, `mem_re=0`, `mem_addr=0`, `done=0`, `busy=0`, `base=0`, `idx=0`, `cnt=0`.
- Reset mid-transfer aborts immediately. No `done` pulse is produced, and the partial byte is discarded.
- `start` sampled at edge k leads to:
  - ISSUE in cycle k+1
  - WAIT in cycle k+2
  - first `out_valid` in cycle k+3
- Per-byte throughput is 3 cycles when `out_ready` is held high.
- A transfer of N≥1 bytes with `out_ready` held high ends with the `done` pulse in cycle k+3N+1, and IDLE resumes in k+3N+2.
- `len=0`: `done` in cycle k+1, no `mem_re`, no `out_valid`.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Structure

- Add `typedef enum logic [2:0] {RD_IDLE, RD_ISSUE, RD_WAIT, RD_PRESENT, RD_DONE} rd_state_t` to the shared `definitions` package.
- Add localparam defaults for `DW` and `AW` to `definitions`.
- Single module, no sub-modules. State register, address/index counter, and output data register all live in one `always_ff` block. Next-state and strobes are computed in one `always_comb` block.

## Test plan

- Reset mid-PRESENT (`reset_n` low asynchronously) -> `out_valid`, `busy`, `mem_re` drop immediately with no clock edge; `done` never pulses.
- `bar_base=0x10`, `len=3`, memory[0x10..0x12]=0xA1,0xB2,0xC3, `out_ready=1` -> `mem_addr` 0x10,0x11,0x12 on `mem_re`; bytes A1,B2,C3 at cycles k+3,k+6,k+9; `done` at k+10.
- `bar_base=0xFE`, `len=4` -> read addresses 0xFE,0xFF,0x00,0x01; 4 bytes out in order.
- Same as the second scenario with `out_ready=0` for 5 cycles on byte 2 -> `out_data=0xB2` held stable with `out_valid=1`; no extra `mem_re`; order intact.
- `len=0` -> `done` one cycle after `start`; zero `mem_re`, zero `out_valid`.
- `start` pulsed again while busy, with `bar_base` changed to 0x80 mid-transfer -> ignored; addresses continue from the original base.
